// File: rtl/signal_generator_one_wire.sv
// Framed test-pattern transmitter for the MUAFR_MISO differential link.
// Sends a fixed pattern, toggle or PRBS7 burst per frame and reports the P edge count of each frame.
module signal_generator_one_wire #(
    parameter int unsigned FRAME_LEN = 1004,
    parameter logic [7:0]  PATTERN   = 8'b00001111
) (
    input  logic        CLK_100MHz,
    input  logic        RST_N,
    input  logic        enable_generate,
    input  logic [1:0]  mode,
    input  logic [7:0]  burst_len,
    output logic        MUAFR_MISO_P,
    output logic        MUAFR_MISO_N,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frame_cnt,
    output logic [11:0] expected_edges,
    output logic [1:0]  dbg_state_o
);

    localparam logic [10:0] FRAME_LAST = 11'(FRAME_LEN);
    localparam logic [10:0] BIT_CAP    = 11'(FRAME_LEN - 8);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_GUARD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic [1:0]  mode_q, mode_d;
    logic [7:0]  blen_q, blen_d;
    logic [6:0]  prbs_q, prbs_d;
    logic        p_q, p_d;
    logic        n_q;
    logic [11:0] acc_q, acc_d;
    logic [11:0] exp_q, exp_d;
    logic [15:0] fcnt_q, fcnt_d;
    logic        done_q, done_d;

    logic [10:0] nbits_cur;
    logic [10:0] nbits_new;
    logic        bit_val;
    logic        p_edge;
    logic        start_frame;

    // The product fits exactly in 11 bits (255*8 = 2040), so no overflow before the cap.
    function automatic logic [10:0] nbits_of(input logic [7:0] len);
        logic [10:0] prod;
        prod = {len, 3'b000};
        return (prod < BIT_CAP) ? prod : BIT_CAP;
    endfunction

    function automatic logic [11:0] sat_inc(input logic [11:0] v);
        return (v == 12'hFFF) ? v : v + 12'd1;
    endfunction

    assign nbits_cur = nbits_of(blen_q);
    assign nbits_new = nbits_of(burst_len);

    always_comb begin
        case (mode_q)
            2'b01:   bit_val = ~p_q;
            2'b10:   bit_val = prbs_q[6];
            default: bit_val = PATTERN[3'd7 - cnt_q[2:0]];
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        blen_d      = blen_q;
        prbs_d      = prbs_q;
        p_d         = p_q;
        acc_d       = acc_q;
        exp_d       = exp_q;
        fcnt_d      = fcnt_q;
        done_d      = 1'b0;
        p_edge      = 1'b0;
        start_frame = 1'b0;

        case (state_q)
            S_IDLE: begin
                p_d = 1'b0;
                if (enable_generate) begin
                    start_frame = 1'b1;
                end
            end
            default: begin
                if (!enable_generate) begin
                    state_d = S_IDLE;
                    p_d     = 1'b0;
                    acc_d   = '0;
                    cnt_d   = '0;
                end else begin
                    if (state_q == S_BURST) begin
                        p_d    = bit_val;
                        prbs_d = {prbs_q[5:0], prbs_q[6] ^ prbs_q[5]};
                        if (cnt_q == nbits_cur - 11'd1) begin
                            state_d = S_GUARD;
                        end
                    end else begin
                        p_d = 1'b0;
                    end
                    p_edge = (p_d != p_q);
                    // The frame-end edge's own transition belongs to the frame being closed.
                    if (cnt_q == FRAME_LAST) begin
                        done_d      = 1'b1;
                        exp_d       = p_edge ? sat_inc(acc_q) : acc_q;
                        acc_d       = '0;
                        fcnt_d      = fcnt_q + 16'd1;
                        start_frame = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 11'd1;
                        if (p_edge) begin
                            acc_d = sat_inc(acc_q);
                        end
                    end
                end
            end
        endcase

        if (start_frame) begin
            cnt_d   = '0;
            mode_d  = mode;
            blen_d  = burst_len;
            prbs_d  = 7'h7F;
            state_d = (nbits_new == 11'd0) ? S_GUARD : S_BURST;
        end
    end

    always_ff @(posedge CLK_100MHz or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mode_q  <= '0;
            blen_q  <= '0;
            prbs_q  <= 7'h7F;
            p_q     <= 1'b0;
            n_q     <= 1'b1;
            acc_q   <= '0;
            exp_q   <= '0;
            fcnt_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            blen_q  <= blen_d;
            prbs_q  <= prbs_d;
            p_q     <= p_d;
            n_q     <= ~p_d;
            acc_q   <= acc_d;
            exp_q   <= exp_d;
            fcnt_q  <= fcnt_d;
            done_q  <= done_d;
        end
    end

    assign MUAFR_MISO_P   = p_q;
    assign MUAFR_MISO_N   = n_q;
    assign busy           = (state_q != S_IDLE);
    assign frame_done     = done_q;
    assign frame_cnt      = fcnt_q;
    assign expected_edges = exp_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_signal_generator_one_wire.sv
// Bench for signal_generator_one_wire: per-frame bitstream checks plus a frame_done scoreboard
// holding {frame_cnt, expected_edges} for every frame the stimulus starts.
module tb_signal_generator_one_wire;

    localparam int FL = 1004;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [1:0]  mode;
    logic [7:0]  burst_len;
    logic        p;
    logic        n;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_cnt;
    logic [11:0] expected_edges;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;
    int n_err = 0;
    int exp_fc = 0;
    int mdl_edges;
    logic mdl [0:FL];
    logic [7:0] pat = 8'b00001111;
    logic [27:0] exp_q[$];

    signal_generator_one_wire #(.FRAME_LEN(FL), .PATTERN(8'b00001111)) dut (
        .CLK_100MHz     (clk),
        .RST_N          (rst_n),
        .enable_generate(enable),
        .mode           (mode),
        .burst_len      (burst_len),
        .MUAFR_MISO_P   (p),
        .MUAFR_MISO_N   (n),
        .busy           (busy),
        .frame_done     (frame_done),
        .frame_cnt      (frame_cnt),
        .expected_edges (expected_edges),
        .dbg_state_o    (dbg_state)
    );

    // clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_p"}, int'(p), 0);
        check({tag, "_n"}, int'(n), 1);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(frame_done), 0);
        check({tag, "_fcnt"}, int'(frame_cnt), 0);
        check({tag, "_edges"}, int'(expected_edges), 0);
        check({tag, "_state"}, int'(dbg_state), 0);
    endtask

    // Expected P sequence for one frame; P is 0 before every frame start.
    task automatic build_model(input logic [1:0] m, input logic [7:0] bl);
        int nb;
        logic [6:0] s;
        logic prev;
        nb = int'(bl) * 8;
        if (nb > FL - 8) nb = FL - 8;
        s = 7'h7F;
        prev = 1'b0;
        mdl_edges = 0;
        for (int i = 0; i <= FL; i++) begin
            if (i < nb) begin
                case (m)
                    2'b01: mdl[i] = (i % 2 == 0);
                    2'b10: begin
                        mdl[i] = s[6];
                        s = {s[5:0], s[6] ^ s[5]};
                    end
                    default: mdl[i] = pat[7 - (i % 8)];
                endcase
            end else begin
                mdl[i] = 1'b0;
            end
            if (mdl[i] != prev) mdl_edges++;
            prev = mdl[i];
        end
    endtask

    // driver: called just after a frame-start edge; ends just after that frame's last edge
    task automatic run_frame(input logic [1:0] m, input logic [7:0] bl,
                             input logic [1:0] m_nx, input logic [7:0] bl_nx,
                             input int exp_edges);
        int bit_err;
        int fd_err;
        int busy_err;
        int e;
        build_model(m, bl);
        e = (exp_edges < 0) ? mdl_edges : exp_edges;
        exp_fc++;
        exp_q.push_back({16'(exp_fc), 12'(e)});
        bit_err = 0;
        fd_err = 0;
        busy_err = 0;
        for (int k = 1; k <= FL + 1; k++) begin
            @(posedge clk);
            #1;
            if (p !== mdl[k-1]) bit_err++;
            if (frame_done !== (k == FL + 1)) fd_err++;
            if (busy !== 1'b1) busy_err++;
            if (k == 500) begin
                mode = m_nx;
                burst_len = bl_nx;
            end
        end
        check($sformatf("bits_m%0d_bl%0d", m, bl), bit_err, 0);
        check($sformatf("done_timing_m%0d_bl%0d", m, bl), fd_err, 0);
        check($sformatf("busy_m%0d_bl%0d", m, bl), busy_err, 0);
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        logic [27:0] e;
        if (n !== ~p) n_err++;
        if (frame_done === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL frame_done_unexpected: got pulse fcnt=%0d edges=%0d, required none",
                         frame_cnt, expected_edges);
            end else begin
                e = exp_q.pop_front();
                if ({frame_cnt, expected_edges} !== e) begin
                    bad++;
                    $display("FAIL frame_result: got fcnt=%0d edges=%0d expected fcnt=%0d edges=%0d",
                             frame_cnt, expected_edges, e[27:12], e[11:0]);
                end
            end
        end
    end

    initial begin
        int fd_seen;
        enable = 1'b0;
        mode = 2'b00;
        burst_len = 8'd10;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");

        @(negedge clk) rst_n = 1'b1;
        @(negedge clk) enable = 1'b1;
        @(posedge clk);
        #1;
        check("busy_on_entry", int'(busy), 1);
        check("state_burst_entry", int'(dbg_state), 1);
        check("p_idle_at_entry", int'(p), 0);

        run_frame(2'b00, 8'd10,  2'b00, 8'd10,  20);
        run_frame(2'b00, 8'd10,  2'b01, 8'd10,  20);
        run_frame(2'b01, 8'd10,  2'b01, 8'd10,  80);
        run_frame(2'b01, 8'd10,  2'b00, 8'd200, 80);
        run_frame(2'b00, 8'd200, 2'b10, 8'd4,   248);
        run_frame(2'b10, 8'd4,   2'b10, 8'd4,   -1);
        run_frame(2'b10, 8'd4,   2'b11, 8'd10,  -1);
        run_frame(2'b11, 8'd10,  2'b00, 8'd10,  20);

        // abort in frame 3 of a fresh run
        @(negedge clk);
        enable = 1'b0;
        rst_n = 1'b0;
        exp_fc = 0;
        mode = 2'b00;
        burst_len = 8'd10;
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk) enable = 1'b1;
        @(posedge clk);
        #1;
        run_frame(2'b00, 8'd10, 2'b00, 8'd10, 20);
        run_frame(2'b00, 8'd10, 2'b00, 8'd10, 20);
        repeat (500) @(posedge clk);
        #1;
        enable = 1'b0;
        @(posedge clk);
        #1;
        check("abort_p", int'(p), 0);
        check("abort_n", int'(n), 1);
        check("abort_busy", int'(busy), 0);
        check("abort_state", int'(dbg_state), 0);
        check("abort_done", int'(frame_done), 0);
        check("abort_fcnt", int'(frame_cnt), 2);
        check("abort_edges", int'(expected_edges), 20);
        fd_seen = 0;
        repeat (1100) begin
            @(posedge clk);
            #1;
            if (frame_done === 1'b1) fd_seen++;
        end
        check("no_done_while_idle", fd_seen, 0);

        enable = 1'b1;
        @(posedge clk);
        #1;
        run_frame(2'b00, 8'd10, 2'b01, 8'd10, 20);

        // asynchronous reset in the middle of a toggle burst
        @(posedge clk);
        #3;
        check("toggle_first_bit", int'(p), 1);
        rst_n = 1'b0;
        #1;
        check_reset("async_reset");

        enable = 1'b0;
        mode = 2'b00;
        burst_len = 8'd0;
        exp_fc = 0;
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk) enable = 1'b1;
        @(posedge clk);
        #1;
        check("state_guard_direct", int'(dbg_state), 2);
        run_frame(2'b00, 8'd0, 2'b00, 8'd0, 0);
        enable = 1'b0;
        @(posedge clk);
        #1;
        check("idle_after_disable", int'(dbg_state), 0);
        repeat (3) @(posedge clk);
        #1;

        // final report
        check("n_complement_errors", n_err, 0);
        check("scoreboard_left", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
